// File: rtl/mem_access.sv
// MIPS memory stage: issues LW/SW on the data bus with a request/response handshake,
// stalls the pipeline while an access is outstanding and registers the writeback bundle.
//   state     | meaning
//   S_IDLE    | no access outstanding; request for a new aligned mem op driven from in_*
//   S_REQ     | request held on the bus (captured fields) until addr_ok
//   S_WAIT_DATA | request accepted, waiting for data_ok
module mem_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_mem_to_reg,
    input  logic              in_mem_write,
    input  logic              in_reg_write,
    input  logic [4:0]        in_wa,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [3:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic              stall,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_wa,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_misalign
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_load, r_store, r_rw, r_flushed;
    logic [4:0]        r_wa;
    logic              r_wb_valid, r_wb_rw, r_wb_mis;
    logic [4:0]        r_wb_wa;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_idle, w_mem_op, w_aligned;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_load, w_store, w_rw;
    logic [4:0]        w_wa;
    logic              w_req, w_stall, w_capture, w_set_flush;
    logic              w_wb_valid_n, w_wb_rw_n, w_wb_mis_n;
    logic [DATA_W-1:0] w_wb_data_n;

    assign w_idle    = (r_state == S_IDLE);
    assign w_mem_op  = in_valid & (in_mem_to_reg | in_mem_write);
    assign w_aligned = (in_addr[1:0] == 2'b00);

    // In IDLE the request is driven straight from the EX/MEM latch; afterwards from the capture.
    assign w_addr  = w_idle ? in_addr : r_addr;
    assign w_wdata = w_idle ? in_wdata : r_wdata;
    assign w_load  = w_idle ? in_mem_to_reg : r_load;
    assign w_store = w_idle ? in_mem_write : r_store;
    assign w_rw    = w_idle ? (in_reg_write & in_mem_to_reg) : r_rw;
    assign w_wa    = w_idle ? in_wa : r_wa;

    always_comb begin
        w_state_nxt  = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_capture    = 1'b0;
        w_set_flush  = 1'b0;
        w_wb_valid_n = 1'b0;
        w_wb_rw_n    = 1'b0;
        w_wb_mis_n   = 1'b0;
        w_wb_data_n  = DATA_W'(w_addr);
        case (r_state)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    if (w_mem_op && w_aligned) begin
                        w_req     = 1'b1;
                        w_stall   = 1'b1;
                        w_capture = 1'b1;
                        if (dresp_addr_ok && dresp_data_ok) begin
                            w_stall      = 1'b0;
                            w_wb_valid_n = 1'b1;
                            w_wb_rw_n    = w_rw;
                            if (w_load) w_wb_data_n = dresp_data;
                        end else if (dresp_addr_ok) begin
                            w_state_nxt = S_WAIT_DATA;
                        end else begin
                            w_state_nxt = S_REQ;
                        end
                    end else if (w_mem_op) begin
                        w_wb_valid_n = 1'b1;
                        w_wb_mis_n   = 1'b1;
                    end else begin
                        w_wb_valid_n = 1'b1;
                        w_wb_rw_n    = in_reg_write;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        w_stall      = 1'b0;
                        w_state_nxt  = S_IDLE;
                        w_wb_valid_n = 1'b1;
                        w_wb_rw_n    = w_rw;
                        if (w_load) w_wb_data_n = dresp_data;
                    end else if (dresp_addr_ok) begin
                        w_state_nxt = S_WAIT_DATA;
                    end
                end
            end
            S_WAIT_DATA: begin
                // Once accepted the bus transaction must close; a flush only hides the result.
                w_stall     = 1'b1;
                w_set_flush = flush;
                if (dresp_data_ok) begin
                    w_stall     = 1'b0;
                    w_state_nxt = S_IDLE;
                    if (!r_flushed && !flush) begin
                        w_wb_valid_n = 1'b1;
                        w_wb_rw_n    = w_rw;
                        if (w_load) w_wb_data_n = dresp_data;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_rw       <= 1'b0;
            r_wa       <= '0;
            r_flushed  <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rw    <= 1'b0;
            r_wb_mis   <= 1'b0;
            r_wb_wa    <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_addr    <= in_addr;
                r_wdata   <= in_wdata;
                r_load    <= in_mem_to_reg;
                r_store   <= in_mem_write;
                r_rw      <= in_reg_write & in_mem_to_reg;
                r_wa      <= in_wa;
                r_flushed <= 1'b0;
            end else if (w_set_flush) begin
                r_flushed <= 1'b1;
            end
            r_wb_valid <= w_wb_valid_n;
            r_wb_rw    <= w_wb_valid_n & w_wb_rw_n;
            r_wb_mis   <= w_wb_valid_n & w_wb_mis_n;
            if (w_wb_valid_n) begin
                r_wb_wa   <= w_wa;
                r_wb_data <= w_wb_data_n;
            end
        end
    end

    // Combinational bus/stall outputs are forced low while reset is held.
    assign dreq_valid   = w_req & ~reset;
    assign stall        = w_stall & ~reset;
    assign dreq_addr    = w_addr;
    assign dreq_data    = w_wdata;
    assign dreq_strobe  = w_store ? 4'hf : 4'h0;
    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_rw;
    assign wb_misalign  = r_wb_mis;
    assign wb_wa        = r_wb_wa;
    assign wb_data      = r_wb_data;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: inputs driven 1ns after posedge, combinational outputs
// checked 2ns after posedge, registered outputs checked in the following cycle.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_mem_to_reg, in_mem_write, in_reg_write;
    logic [4:0]  in_wa;
    logic [31:0] in_addr, in_wdata;
    logic        flush;
    logic        dreq_valid;
    logic [31:0] dreq_addr, dreq_data;
    logic [3:0]  dreq_strobe;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        stall, wb_valid, wb_reg_write, wb_misalign;
    logic [4:0]  wb_wa;
    logic [31:0] wb_data;

    int checks = 0;
    int failures = 0;

    mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mem_to_reg(in_mem_to_reg),
        .in_mem_write(in_mem_write), .in_reg_write(in_reg_write), .in_wa(in_wa),
        .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
        .dreq_data(dreq_data), .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data), .stall(stall), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_wa(wb_wa), .wb_data(wb_data), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_mem_to_reg = 0; in_mem_write = 0; in_reg_write = 0;
        in_wa = 0; in_addr = 0; in_wdata = 0; flush = 0;
        dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = 0;
    endtask

    task automatic drive_lw(input logic [31:0] a, input logic [4:0] wa);
        in_valid = 1; in_mem_to_reg = 1; in_mem_write = 0; in_reg_write = 1;
        in_addr = a; in_wa = wa;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        #12;
        checks++; if (dreq_valid !== 1'b0) begin failures++; $display("FAIL rst_dreq got=%0b exp=0", dreq_valid); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall); end
        checks++; if ({wb_valid, wb_reg_write, wb_misalign} !== 3'b000) begin failures++; $display("FAIL rst_wbflags got=%b exp=000", {wb_valid, wb_reg_write, wb_misalign}); end
        checks++; if ({wb_wa, wb_data} !== 37'd0) begin failures++; $display("FAIL rst_wbdata got=%h exp=0", {wb_wa, wb_data}); end
        @(negedge clk);
        reset = 0;
        step();
    endtask

    task automatic test_alu();
        in_valid = 1; in_reg_write = 1; in_addr = 32'h1234; in_wa = 5;
        #1;
        checks++; if (stall !== 1'b0 || dreq_valid !== 1'b0) begin failures++; $display("FAIL alu_nostall got=%0b%0b exp=00", stall, dreq_valid); end
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1) begin failures++; $display("FAIL alu_wbv got=%0b%0b exp=11", wb_valid, wb_reg_write); end
        checks++; if (wb_data !== 32'h1234 || wb_wa !== 5'd5) begin failures++; $display("FAIL alu_data got=%h/%0d exp=1234/5", wb_data, wb_wa); end
        step();
        checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%0b%0b exp=00", wb_valid, wb_reg_write); end
    endtask

    task automatic test_lw();
        drive_lw(32'h100, 5'd7);
        #1;
        checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h100 || dreq_strobe !== 4'h0) begin failures++; $display("FAIL lw_req1 got=%0b/%h/%h exp=1/100/0", dreq_valid, dreq_addr, dreq_strobe); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lw_stall1 got=%0b exp=1", stall); end
        step();
        in_addr = 32'hFFF0; dresp_addr_ok = 1;
        #1;
        checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h100 || stall !== 1'b1) begin failures++; $display("FAIL lw_req2 got=%0b/%h/%0b exp=1/100/1", dreq_valid, dreq_addr, stall); end
        step();
        dresp_addr_ok = 0;
        #1;
        checks++; if (dreq_valid !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL lw_wait got=%0b/%0b/%0b exp=0/1/0", dreq_valid, stall, wb_valid); end
        step();
        dresp_data_ok = 1; dresp_data = 32'hDEADBEEF;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_stall4 got=%0b exp=0", stall); end
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_wa !== 5'd7 || wb_reg_write !== 1'b1) begin failures++; $display("FAIL lw_wb got=%0b/%h/%0d/%0b exp=1/deadbeef/7/1", wb_valid, wb_data, wb_wa, wb_reg_write); end
        step();
    endtask

    task automatic test_sw();
        in_valid = 1; in_mem_write = 1; in_reg_write = 0; in_addr = 32'h200; in_wdata = 32'hCAFE; in_wa = 3;
        #1;
        checks++; if (dreq_valid !== 1'b1 || dreq_strobe !== 4'hf || dreq_data !== 32'hCAFE || stall !== 1'b1) begin failures++; $display("FAIL sw_req got=%0b/%h/%h/%0b exp=1/f/cafe/1", dreq_valid, dreq_strobe, dreq_data, stall); end
        step();
        dresp_addr_ok = 1; dresp_data_ok = 1;
        #1;
        checks++; if (stall !== 1'b0 || dreq_valid !== 1'b1) begin failures++; $display("FAIL sw_done got=%0b/%0b exp=0/1", stall, dreq_valid); end
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || wb_data !== 32'h200) begin failures++; $display("FAIL sw_wb got=%0b/%0b/%h exp=1/0/200", wb_valid, wb_reg_write, wb_data); end
        step();
    endtask

    task automatic test_misalign();
        drive_lw(32'h102, 5'd9);
        #1;
        checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL mis_noreq got=%0b/%0b exp=0/0", dreq_valid, stall); end
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_misalign !== 1'b1 || wb_reg_write !== 1'b0) begin failures++; $display("FAIL mis_wb got=%0b/%0b/%0b exp=1/1/0", wb_valid, wb_misalign, wb_reg_write); end
        step();
        checks++; if (wb_valid !== 1'b0 || wb_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0b/%0b exp=0/0", wb_valid, wb_misalign); end
    endtask

    task automatic test_flush_wait();
        drive_lw(32'h300, 5'd4);
        step();
        dresp_addr_ok = 1;
        step();
        dresp_addr_ok = 0; flush = 1;
        #1;
        checks++; if (stall !== 1'b1 || dreq_valid !== 1'b0) begin failures++; $display("FAIL flw_hold got=%0b/%0b exp=1/0", stall, dreq_valid); end
        step();
        flush = 0; dresp_data_ok = 1; dresp_data = 32'h5555AAAA;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flw_close got=%0b exp=0", stall); end
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0) begin failures++; $display("FAIL flw_nowb got=%0b/%0b exp=0/0", wb_valid, wb_reg_write); end
        drive_lw(32'h400, 5'd6);
        #1;
        checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h400) begin failures++; $display("FAIL flw_next_req got=%0b/%h exp=1/400", dreq_valid, dreq_addr); end
        step();
        dresp_addr_ok = 1; dresp_data_ok = 1; dresp_data = 32'h12345678;
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h12345678 || wb_wa !== 5'd6) begin failures++; $display("FAIL flw_next_wb got=%0b/%h/%0d exp=1/12345678/6", wb_valid, wb_data, wb_wa); end
        step();
    endtask

    task automatic test_flush_idle_req();
        in_valid = 1; in_reg_write = 1; in_addr = 32'h77; in_wa = 2; flush = 1;
        step();
        idle_inputs();
        #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL fli_nowb got=%0b exp=0", wb_valid); end
        drive_lw(32'h500, 5'd8);
        step();
        flush = 1;
        #1;
        checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL flr_drop got=%0b/%0b exp=0/0", dreq_valid, stall); end
        step();
        idle_inputs();
        #1;
        checks++; if (dreq_valid !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL flr_idle got=%0b/%0b exp=0/0", dreq_valid, wb_valid); end
        dresp_data_ok = 1; dresp_data = 32'h99;
        step();
        dresp_data_ok = 0;
        #1;
        checks++; if (wb_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL stray_dataok got=%0b/%0b exp=0/0", wb_valid, stall); end
    endtask

    task automatic test_reset_in_req();
        drive_lw(32'h600, 5'd1);
        step();
        #2;
        checks++; if (dreq_valid !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL rreq_pre got=%0b/%0b exp=1/1", dreq_valid, stall); end
        reset = 1;
        #1;
        checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rreq_drop got=%0b/%0b exp=0/0", dreq_valid, stall); end
        step();
        idle_inputs();
        @(negedge clk);
        reset = 0;
        step();
        #1;
        checks++; if (dreq_valid !== 1'b0 || stall !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL rreq_after got=%0b/%0b/%0b exp=0/0/0", dreq_valid, stall, wb_valid); end
        drive_lw(32'h700, 5'd2);
        #1;
        checks++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h700) begin failures++; $display("FAIL rreq_idle_req got=%0b/%h exp=1/700", dreq_valid, dreq_addr); end
        step();
        idle_inputs();
        flush = 1;
        step();
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_sw();
        test_misalign();
        test_flush_wait();
        test_flush_idle_req();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
